// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch constants: text segment bounds, reset PC and the NOP used for faulting fetches.
// FETCH_FAULT_EN enables is_fetch_fault() users in the fetch unit.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] TEXT_BEGIN      = 32'h0040_0000;
  localparam logic [31:0] TEXT_END        = 32'h0040_FFFF;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  // Misaligned or outside the text segment.
  function automatic logic is_fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_BEGIN) || (pc > TEXT_END);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry instruction FIFO of {pc, instruction[, fault]} with push, pop and synchronous flush.
// FETCH_FAULT_EN adds a per-entry fault bit.
module fetch_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instruction,
`ifdef FETCH_FAULT_EN
  input  logic        push_fault,
  output logic        head_fault,
`endif
  input  logic        pop,
  output logic [1:0]  count,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_instruction
);

  logic [31:0] pc_q    [2];
  logic [31:0] pc_d    [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
`ifdef FETCH_FAULT_EN
  logic        fault_q [2];
  logic        fault_d [2];
`endif
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
`ifdef FETCH_FAULT_EN
    fault_d  = fault_q;
`endif
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]    = push_pc;
        instr_d[wr_ptr_q] = push_instruction;
`ifdef FETCH_FAULT_EN
        fault_d[wr_ptr_q] = push_fault;
`endif
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: storage is cleared on reset so the head outputs read zero, not stale data.
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
`ifdef FETCH_FAULT_EN
        fault_q[i] <= 1'b0;
`endif
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
`ifdef FETCH_FAULT_EN
      fault_q  <= fault_d;
`endif
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count            = count_q;
  assign head_valid       = (count_q != 2'd0);
  assign head_pc          = pc_q[rd_ptr_q];
  assign head_instruction = instr_q[rd_ptr_q];
`ifdef FETCH_FAULT_EN
  assign head_fault       = fault_q[rd_ptr_q];
`endif

  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
    !(push && !pop && !flush && count_q == 2'd2));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, tags one-cycle-late text memory data and queues it for decode.
// FETCH_FAULT_EN: flag misaligned/out-of-text fetches, substitute a NOP and halt until redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = TEXT_BEGIN,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_valid_q, inflight_valid_d;
  logic [1:0]  count;
  logic [2:0]  occupancy;
  logic        pop, issue;
  logic [31:0] push_instruction;
`ifdef FETCH_FAULT_EN
  logic        inflight_fault_q, inflight_fault_d;
  logic        halted_q, halted_d;
  logic        head_fault;
`endif

  assign pop = out_valid && out_ready;

  // Queued entries after this edge's pop plus the response already in flight must leave room.
  always_comb begin
    occupancy        = {1'b0, count} - {2'b00, pop} + {2'b00, inflight_valid_q};
    issue            = !redirect_valid && (occupancy < 3'(BUFFER_DEPTH));
`ifdef FETCH_FAULT_EN
    issue            = issue && !halted_q;
    inflight_fault_d = 1'b0;
    halted_d         = halted_q;
`endif
    fetch_pc_d       = fetch_pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
`ifdef FETCH_FAULT_EN
      halted_d   = 1'b0;
`endif
    end else if (issue) begin
      fetch_pc_d       = fetch_pc_q + 32'd4;
      inflight_pc_d    = fetch_pc_q;
      inflight_valid_d = 1'b1;
`ifdef FETCH_FAULT_EN
      inflight_fault_d = is_fetch_fault(fetch_pc_q);
      halted_d         = is_fetch_fault(fetch_pc_q);
`endif
    end
  end

`ifdef FETCH_FAULT_EN
  assign push_instruction = inflight_fault_q ? NOP_INSTRUCTION : imem_data;
`else
  assign push_instruction = imem_data;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
`ifdef FETCH_FAULT_EN
      inflight_fault_q <= 1'b0;
      halted_q         <= 1'b0;
`endif
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
`ifdef FETCH_FAULT_EN
      inflight_fault_q <= inflight_fault_d;
      halted_q         <= halted_d;
`endif
    end
  end

  assign imem_address = fetch_pc_q;

  fetch_buffer u_fetch_buffer (
    .clock            (clock),
    .reset            (reset),
    .flush            (redirect_valid),
    .push             (inflight_valid_q),
    .push_pc          (inflight_pc_q),
    .push_instruction (push_instruction),
`ifdef FETCH_FAULT_EN
    .push_fault       (inflight_fault_q),
    .head_fault       (head_fault),
`endif
    .pop              (pop),
    .count            (count),
    .head_valid       (out_valid),
    .head_pc          (out_pc),
    .head_instruction (out_instruction)
  );

`ifdef FETCH_FAULT_EN
  assign out_fault = head_fault;
`else
  assign out_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: in-order PC scoreboard, directed latency cases,
// randomized ready/redirect traffic. FETCH_FAULT_EN adds the faulting-fetch scenarios.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_handshakes = 0;

  // Reference model: the next PC decode must receive, plus the held head under backpressure.
  logic [31:0] exp_pc;
  logic        mon_en;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  instruction_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_fault       (out_fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Text memory: data for the address presented this cycle appears in the next cycle.
  initial begin
    logic [31:0] a;
    imem_data = '0;
    forever begin
      @(negedge clock);
      a = imem_address;
      @(posedge clock);
      #1;
      imem_data = a ^ KEY;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare the current head against the model given the inputs about to be sampled.
  task automatic observe();
    if (!mon_en) return;
    if (hold_v) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_pc", out_pc, hold_pc);
      check("hold_instr", out_instruction, hold_instr);
    end
    if (out_valid && out_ready) begin
      check("order_pc", out_pc, exp_pc);
      check("order_instr", out_instruction, exp_pc ^ KEY);
      check("order_fault", {31'd0, out_fault}, 32'd0);
      exp_pc = exp_pc + 32'd4;
      n_handshakes++;
    end
    hold_v     = out_valid && !out_ready;
    hold_pc    = out_pc;
    hold_instr = out_instruction;
  endtask

  // Called at a negedge: apply inputs, score them, advance one edge, return at the next negedge.
  task automatic drive(input logic rdy, input logic rv = 1'b0, input logic [31:0] rpc = '0);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    observe();
    if (rv) begin
      exp_pc = rpc;
      hold_v = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mon_en         = 1'b0;
    hold_v         = 1'b0;
    exp_pc         = RESET_PC;
    @(negedge clock);

    // Reset held for three edges.
    repeat (3) begin
      drive(1'b1);
      check("rst_addr", imem_address, RESET_PC);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_instr", out_instruction, 32'd0);
      check("rst_fault", {31'd0, out_fault}, 32'd0);
    end

    // First fetch: visible after the second edge with reset released.
    reset  = 1'b1;
    mon_en = 1'b1;
    exp_pc = RESET_PC;
    drive(1'b1);
    check("first_not_yet", {31'd0, out_valid}, 32'd0);
    drive(1'b1);
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_pc", out_pc, RESET_PC);

    // Streaming at one per cycle.
    repeat (8) begin
      drive(1'b1);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
    end

    // Backpressure: head held, fetch stops two ahead of the head.
    repeat (5) drive(1'b0);
    check("bp_addr_frozen", imem_address, out_pc + 32'd8);
    check("bp_head_expected", out_pc, exp_pc);
    repeat (6) begin
      drive(1'b1);
      check("resume_valid", {31'd0, out_valid}, 32'd1);
    end

    // Fill the queue with 0x00400010/14, then redirect.
    drive(1'b0, 1'b1, 32'h0040_0010);
    repeat (4) drive(1'b0);
    check("full_head", out_pc, 32'h0040_0010);
    check("full_addr", imem_address, 32'h0040_0018);
    drive(1'b0, 1'b1, 32'h0040_0100);
    check("redir_flush0", {31'd0, out_valid}, 32'd0);
    drive(1'b1);
    check("redir_flush1", {31'd0, out_valid}, 32'd0);
    drive(1'b1);
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h0040_0100);

    // Back-to-back redirects: the last one wins.
    drive(1'b1, 1'b1, 32'h0040_0200);
    drive(1'b1, 1'b1, 32'h0040_0300);
    check("b2b_flush", {31'd0, out_valid}, 32'd0);
    drive(1'b1);
    drive(1'b1);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_pc", out_pc, 32'h0040_0300);

`ifndef FETCH_FAULT_EN
    // PC wraps silently at 2^32.
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) drive(1'b1);
    check("wrap_pc", out_pc, 32'h0000_0008);
`endif

    // Randomized ready and occasional redirects inside the text segment.
    for (int i = 0; i < 400; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 31) == 0);
      rpc = RESET_PC + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      drive(rdy, rv, rpc);
    end
    check("random_progress", {31'd0, n_handshakes > 250}, 32'd1);

    // Reset in the middle of a stream.
    repeat (4) drive(1'b1);
    mon_en = 1'b0;
    reset  = 1'b0;
    drive(1'b1);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_pc", out_pc, 32'd0);
    check("midrst_addr", imem_address, RESET_PC);
    reset  = 1'b1;
    exp_pc = RESET_PC;
    hold_v = 1'b0;
    mon_en = 1'b1;
    drive(1'b1);
    check("midrst_not_yet", {31'd0, out_valid}, 32'd0);
    drive(1'b1);
    check("midrst_restart_valid", {31'd0, out_valid}, 32'd1);
    check("midrst_restart_pc", out_pc, RESET_PC);
    repeat (4) drive(1'b1);

`ifdef FETCH_FAULT_EN
    // Faulting fetches: one NOP entry with fault set, then issue halts.
    mon_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] bad_pc;
      bad_pc = (k == 0) ? 32'h0040_0102 : 32'h1001_0000;
      drive(1'b1, 1'b1, bad_pc);
      drive(1'b1);
      drive(1'b1);
      check("fault_valid", {31'd0, out_valid}, 32'd1);
      check("fault_bit", {31'd0, out_fault}, 32'd1);
      check("fault_pc", out_pc, bad_pc);
      check("fault_instr", out_instruction, NOP);
      repeat (6) begin
        drive(1'b1);
        check("fault_halted", {31'd0, out_valid}, 32'd0);
      end
    end
    drive(1'b1, 1'b1, RESET_PC + 32'h40);
    hold_v = 1'b0;
    mon_en = 1'b1;
    drive(1'b1);
    drive(1'b1);
    check("fault_recover_pc", out_pc, RESET_PC + 32'h40);
    repeat (4) drive(1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
